pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: number of CLK cycles the lock must stay high before the frequency check starts (range 2..65535).
REQ-002 SHALL have parameter EXP_COUNT, default 32: expected CLK cycles between successive REF_TOGGLE edges (32 MHz CLK, 16 MHz reference divided by 16); 2*EXP_COUNT SHALL be at most 254.
REQ-003 SHALL have parameter TOL, default 2: allowed deviation of one measurement from EXP_COUNT, in cycles.
REQ-004 SHALL have parameter GOOD_N, default 4: number of consecutive in-window measurements required to release reset.
REQ-005 CLK  in  1  PLL output clock; the only clock in the block.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 PLL_LOCK  in  1  PLL lock indicator, asynchronous to CLK.
REQ-008 REF_TOGGLE  in  1  reference-domain divided toggle, asynchronous to CLK.
REQ-009 RST_OUT_N  out  1  registered active-low reset for downstream logic.
REQ-010 READY  out  1  high only in RUN.
REQ-011 FREQ_ERR  out  1  sticky frequency fault flag.
REQ-012 MEAS  out  8  last captured edge-to-edge cycle count.
REQ-013 LOCK_LOSS_CNT  out  8  saturating count of lock losses seen in RUN.

Function
REQ-014 SHALL pass PLL_LOCK and REF_TOGGLE through two-flop synchronizers (lock_s, ref_s) and SHALL detect a ref edge when ref_s differs from its one-cycle-delayed copy (either polarity).
REQ-015 SHALL implement states WAIT_LOCK, SETTLE, CHECK, RUN and FAULT; the state after reset SHALL be WAIT_LOCK.
REQ-016 WAIT_LOCK: when lock_s is 1, the block SHALL clear the settle counter and go to SETTLE.
REQ-017 SETTLE: the settle counter SHALL increment each cycle; when lock_s is 0 the block SHALL go to WAIT_LOCK; when the counter reaches STABLE_CYCLES-1 the block SHALL go to CHECK.
REQ-018 Measurement counter (8-bit): SHALL increment every cycle; on a ref edge it SHALL load MEAS with count+1 and restart at 0; on reaching 2*EXP_COUNT with no edge it SHALL load MEAS with 8'hFF, restart, and count as a bad measurement.
REQ-019 A measurement is good when abs(MEAS-EXP_COUNT) is at most TOL, and bad otherwise.
REQ-020 CHECK: the first edge after entering CHECK SHALL be discarded (counter resynchronised only). After GOOD_N consecutive good measurements the block SHALL go to RUN. A bad measurement SHALL reset the good counter and send the block to FAULT.
REQ-021 RUN: RST_OUT_N=1 and READY=1. When lock_s is 0, the block SHALL go to WAIT_LOCK and increment LOCK_LOSS_CNT, saturating at 255. A bad measurement SHALL send the block to FAULT.
REQ-022 FAULT: the block SHALL set FREQ_ERR, reuse the settle counter as a hold-off of STABLE_CYCLES cycles, and then go to CHECK. When lock_s is 0, the block SHALL go to WAIT_LOCK; lock-loss priority over hold-off.
REQ-023 RST_OUT_N SHALL be 0 in every state except RUN; it is registered, so it SHALL fall on the cycle after lock_s falls while in RUN (at most 3 CLK cycles after PLL_LOCK falls).
REQ-024 Simultaneous lock loss and bad measurement in RUN: lock loss SHALL win, and FREQ_ERR SHALL be unchanged.
REQ-025 PLL_LOCK glitches shorter than 2 CLK cycles may be missed; any lock_s low during SETTLE SHALL restart settling from 0.

Reset
REQ-026 While RESET is 0: state=WAIT_LOCK, RST_OUT_N=0, READY=0, FREQ_ERR=0, MEAS=0, LOCK_LOSS_CNT=0, all counters and synchronizers 0.
REQ-027 RESET asserted mid-operation SHALL force all outputs to their reset values immediately (asynchronously); release SHALL restart from WAIT_LOCK.

Verification
REQ-028 Nominal startup: PLL_LOCK=1, REF_TOGGLE edges every 32 CLK cycles, defaults -> RST_OUT_N rises after 1024 settle cycles + 1 discarded edge + 4 good edges; MEAS=32; FREQ_ERR=0.
REQ-029 Tolerance edges: periods of 30 and 34 -> RUN reached. Period 35 -> FAULT, FREQ_ERR=1, RST_OUT_N=0, MEAS=35.
REQ-030 Missing reference: REF_TOGGLE held constant while in RUN -> after 64 cycles MEAS=8'hFF, state FAULT, RST_OUT_N=0.
REQ-031 Lock loss in RUN: PLL_LOCK falls -> RST_OUT_N=0 within 3 cycles and LOCK_LOSS_CNT increments by 1. Repeat 260 times -> LOCK_LOSS_CNT=255.
REQ-032 Lock glitch during SETTLE at cycle 500 for 4 cycles -> settle restarts, and RST_OUT_N stays 0 for at least 1024 further cycles.
REQ-033 Async reset while in RUN with FREQ_ERR=1 -> all outputs at reset values without a CLK edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds downstream logic in reset until the PLL is locked,
// stable, and its output frequency matches the divided reference within tolerance.
module pll_lock_supervisor #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned EXP_COUNT     = 32,
  parameter int unsigned TOL           = 2,
  parameter int unsigned GOOD_N        = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_lock_i,
  input  logic       ref_toggle_i,
  output logic       rst_out_no,
  output logic       ready_o,
  output logic       freq_err_o,
  output logic [7:0] meas_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned SW = 16;
  localparam int unsigned MW = 8;
  localparam int unsigned GW = 8;

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [MW-1:0] TIMEOUT_LAST = MW'(2 * EXP_COUNT - 1);
  localparam logic [MW-1:0] EXP_VAL      = MW'(EXP_COUNT);
  localparam logic [MW-1:0] TOL_VAL      = MW'(TOL);
  localparam logic [GW-1:0] GOOD_LAST    = GW'(GOOD_N - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    CHECK     = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          lock_meta_q, lock_s_q;
  logic          ref_meta_q, ref_s_q, ref_d_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [GW-1:0] good_q, good_d;
  logic          first_q, first_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [MW-1:0] meas_q, meas_d;
  logic [MW-1:0] llc_q, llc_d;
  logic          freq_err_q, freq_err_d;
  logic          rst_out_q, ready_q;
  logic          run_d;

  logic          ref_edge_c, timeout_c, meas_evt_c, meas_good_c, discard_c;
  logic [MW-1:0] meas_new_c, diff_c;

  // Measurement event decode: an edge ends a period, a missing edge times out as 8'hFF
  always_comb begin
    ref_edge_c  = ref_s_q ^ ref_d_q;
    timeout_c   = !ref_edge_c && (mcnt_q == TIMEOUT_LAST);
    meas_evt_c  = ref_edge_c || timeout_c;
    meas_new_c  = ref_edge_c ? (mcnt_q + MW'(1)) : 8'hFF;
    diff_c      = (meas_new_c >= EXP_VAL) ? (meas_new_c - EXP_VAL) : (EXP_VAL - meas_new_c);
    meas_good_c = (diff_c <= TOL_VAL);
    discard_c   = (state_q == CHECK) && first_q && ref_edge_c;
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    good_d     = good_q;
    first_d    = first_q;
    freq_err_d = freq_err_q;
    llc_d      = llc_q;
    mcnt_d     = meas_evt_c ? '0 : (mcnt_q + MW'(1));
    meas_d     = (meas_evt_c && !discard_c) ? meas_new_c : meas_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
          first_d = 1'b1;
          good_d  = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CHECK: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (meas_evt_c) begin
          if (discard_c) begin
            first_d = 1'b0;
          end else if (!meas_good_c) begin
            good_d     = '0;
            settle_d   = '0;
            freq_err_d = 1'b1;
            state_d    = FAULT;
          end else if (good_q == GOOD_LAST) begin
            good_d  = '0;
            state_d = RUN;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      RUN: begin
        // Lock loss outranks a simultaneous bad measurement
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (llc_q != 8'hFF) llc_d = llc_q + MW'(1);
        end else if (meas_evt_c && !meas_good_c) begin
          settle_d   = '0;
          freq_err_d = 1'b1;
          state_d    = FAULT;
        end
      end
      FAULT: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
          first_d = 1'b1;
          good_d  = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_LOCK;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      ref_meta_q  <= 1'b0;
      ref_s_q     <= 1'b0;
      ref_d_q     <= 1'b0;
      settle_q    <= '0;
      good_q      <= '0;
      first_q     <= 1'b0;
      mcnt_q      <= '0;
      meas_q      <= '0;
      llc_q       <= '0;
      freq_err_q  <= 1'b0;
      rst_out_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
      ref_meta_q  <= ref_toggle_i;
      ref_s_q     <= ref_meta_q;
      ref_d_q     <= ref_s_q;
      settle_q    <= settle_d;
      good_q      <= good_d;
      first_q     <= first_d;
      mcnt_q      <= mcnt_d;
      meas_q      <= meas_d;
      llc_q       <= llc_d;
      freq_err_q  <= freq_err_d;
      rst_out_q   <= run_d;
      ready_q     <= run_d;
    end
  end

  assign rst_out_no      = rst_out_q;
  assign ready_o         = ready_q;
  assign freq_err_o      = freq_err_q;
  assign meas_o          = meas_q;
  assign lock_loss_cnt_o = llc_q;

endmodule
